// File: rtl/z80_bus_cycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : z80_bus_cycle_ctrl_if
//  Description : Bundle for z80_bus_cycle_ctrl. It carries two groups of
//                signals:
//                  - the request side (req/op/addr/wdata in,
//                    ready/done/rdata out), and
//                  - the external Z80 bus (address, data, strobes, WAIT).
//                The slave modport is the controller's view.
//                The master modport is the view of the requester and the bus
//                model.
//  Revision    : 1.0  initial release
// ============================================================================
interface z80_bus_cycle_ctrl_if;
  // request side
  logic        req;      // request valid, held until accepted
  logic [1:0]  op;       // 00 mem rd, 01 mem wr, 10 io rd, 11 io wr
  logic [15:0] addr;     // cycle address
  logic [7:0]  wdata;    // write data
  logic        ready;    // controller can accept this edge
  logic        done;     // one-cycle completion pulse
  logic [7:0]  rdata;    // last read data
  // external bus
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_doe;
  logic [7:0]  bus_din;
  logic        mreq_n;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic        wait_n;

  modport slave (
    input  req, op, addr, wdata, bus_din, wait_n,
    output ready, done, rdata, bus_addr, bus_dout, bus_doe,
           mreq_n, iorq_n, rd_n, wr_n
  );

  modport master (
    output req, op, addr, wdata, bus_din, wait_n,
    input  ready, done, rdata, bus_addr, bus_dout, bus_doe,
           mreq_n, iorq_n, rd_n, wr_n
  );
endinterface
`default_nettype wire

// File: rtl/z80_bus_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : z80_bus_cycle_ctrl
//  Description : Runs one Z80 external bus machine cycle per accepted request
//                (mem read, mem write, I/O read, I/O write).
//                  - Steps T1, T2, TW*, T3 at one T-state per clk.
//                  - Drives the address, data and strobes.
//                  - Samples wait_n.
//                  - Returns read data together with a done pulse.
//  Ports       : clk     - system clock
//                reset   - synchronous, active-high reset
//                bus     - z80_bus_cycle_ctrl_if.slave:
//                            request side: req/op/addr/wdata -> ready/done/rdata
//                            bus side:     bus_addr/bus_dout/bus_doe/bus_din,
//                                          mreq_n/iorq_n/rd_n/wr_n/wait_n
//  Parameters  : IO_WAIT_STATES - automatic TW states after T2 for I/O (0..7)
//  Revision    : 1.0  initial release
// ============================================================================
module z80_bus_cycle_ctrl #(
  parameter int IO_WAIT_STATES = 1
) (
  input wire                  clk,
  input wire                  reset,
  z80_bus_cycle_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T1   = 3'd1;
  localparam logic [2:0] S_T2   = 3'd2;
  localparam logic [2:0] S_TW   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;

  localparam logic [2:0] c_IO_WAIT = 3'(IO_WAIT_STATES);

  logic [2:0]  r_state;
  logic [1:0]  r_op;
  logic [2:0]  r_wcnt;
  logic [15:0] r_bus_addr;
  logic [7:0]  r_bus_dout;
  logic        r_bus_doe;
  logic        r_mreq_n;
  logic        r_iorq_n;
  logic        r_rd_n;
  logic        r_wr_n;
  logic        r_done;
  logic [7:0]  r_rdata;

  logic        w_ready;
  logic        w_accept;
  logic [2:0]  w_nstate;
  logic [1:0]  w_nop;
  logic        w_in_cycle;  // next state is T1..T3
  logic        w_late;      // next state is T2..T3

  assign w_ready  = (r_state == S_IDLE) || (r_state == S_T3);
  assign w_accept = bus.req && w_ready;
  // The op that owns the next state: a freshly accepted one wins over the latch.
  assign w_nop    = w_accept ? bus.op : r_op;

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE:     w_nstate = w_accept ? S_T1 : S_IDLE;
      S_T1:       w_nstate = S_T2;
      S_T2, S_TW: begin
        // Automatic I/O waits run first; wait_n only matters once they expire.
        if (r_wcnt != 3'd0)   w_nstate = S_TW;
        else if (bus.wait_n)  w_nstate = S_T3;
        else                  w_nstate = S_TW;
      end
      S_T3:       w_nstate = w_accept ? S_T1 : S_IDLE;
      default:    w_nstate = S_IDLE;
    endcase
  end

  assign w_in_cycle = (w_nstate == S_T1) || (w_nstate == S_T2) ||
                      (w_nstate == S_TW) || (w_nstate == S_T3);
  assign w_late     = (w_nstate == S_T2) || (w_nstate == S_TW) ||
                      (w_nstate == S_T3);

  // Bus outputs are registered from the next-state decode.
  // Each registered value is therefore the one belonging to the state being
  // entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op       <= 2'b00;
      r_wcnt     <= 3'd0;
      r_bus_addr <= 16'h0000;
      r_bus_dout <= 8'h00;
      r_bus_doe  <= 1'b0;
      r_mreq_n   <= 1'b1;
      r_iorq_n   <= 1'b1;
      r_rd_n     <= 1'b1;
      r_wr_n     <= 1'b1;
      r_done     <= 1'b0;
      r_rdata    <= 8'h00;
    end else begin
      r_state <= w_nstate;

      if (w_accept) begin
        r_op       <= bus.op;
        r_wcnt     <= bus.op[1] ? c_IO_WAIT : 3'd0;
        r_bus_addr <= bus.addr;
        // Only writes touch the data bus register; otherwise it holds.
        if (bus.op[0]) r_bus_dout <= bus.wdata;
      end else if (((r_state == S_T2) || (r_state == S_TW)) && (r_wcnt != 3'd0)) begin
        r_wcnt <= r_wcnt - 3'd1;
      end

      // Memory cycles assert MREQ from T1; I/O cycles assert IORQ from T2.
      r_mreq_n  <= !(w_in_cycle && !w_nop[1]);
      r_iorq_n  <= !(w_late && w_nop[1]);
      // Memory reads assert RD from T1; I/O reads assert RD from T2.
      r_rd_n    <= !(!w_nop[0] && (w_nop[1] ? w_late : w_in_cycle));
      r_wr_n    <= !(w_nop[0] && w_late);
      r_bus_doe <= w_in_cycle && w_nop[0];

      r_done <= (r_state == S_T3);
      if ((r_state == S_T3) && !r_op[0]) r_rdata <= bus.bus_din;
    end
  end

  assign bus.ready    = w_ready;
  assign bus.done     = r_done;
  assign bus.rdata    = r_rdata;
  assign bus.bus_addr = r_bus_addr;
  assign bus.bus_dout = r_bus_dout;
  assign bus.bus_doe  = r_bus_doe;
  assign bus.mreq_n   = r_mreq_n;
  assign bus.iorq_n   = r_iorq_n;
  assign bus.rd_n     = r_rd_n;
  assign bus.wr_n     = r_wr_n;

endmodule
`default_nettype wire

// File: tb/tb_z80_bus_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_z80_bus_cycle_ctrl
//  Description : Directed self-checking bench for z80_bus_cycle_ctrl.
//                Two instances are used: IO_WAIT_STATES = 1 and 3.
//                Status vector = {ready, done, mreq_n, iorq_n, rd_n, wr_n,
//                bus_doe}.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_z80_bus_cycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;      // 0 drives/observes the IO_WAIT=1 unit, 1 the IO_WAIT=3 unit
  logic        req;
  logic [1:0]  op;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  bus_din;
  logic        wait_n;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [6:0] c_IDLE = 7'b1011110;
  localparam logic [6:0] c_DONE = 7'b1111110;

  always #5 clk = ~clk;

  z80_bus_cycle_ctrl_if b1 ();
  z80_bus_cycle_ctrl_if b3 ();

  assign b1.req = req && !sel;
  assign b3.req = req && sel;
  assign b1.op = op;           assign b3.op = op;
  assign b1.addr = addr;       assign b3.addr = addr;
  assign b1.wdata = wdata;     assign b3.wdata = wdata;
  assign b1.bus_din = bus_din; assign b3.bus_din = bus_din;
  assign b1.wait_n = wait_n;   assign b3.wait_n = wait_n;

  z80_bus_cycle_ctrl #(.IO_WAIT_STATES(1)) u_dut1 (.clk(clk), .reset(reset), .bus(b1));
  z80_bus_cycle_ctrl #(.IO_WAIT_STATES(3)) u_dut3 (.clk(clk), .reset(reset), .bus(b3));

  logic [6:0]  w_status;
  logic [15:0] w_addr;
  logic [7:0]  w_dout;
  logic [7:0]  w_rdata;
  assign w_status = sel ? {b3.ready, b3.done, b3.mreq_n, b3.iorq_n, b3.rd_n, b3.wr_n, b3.bus_doe}
                        : {b1.ready, b1.done, b1.mreq_n, b1.iorq_n, b1.rd_n, b1.wr_n, b1.bus_doe};
  assign w_addr  = sel ? b3.bus_addr : b1.bus_addr;
  assign w_dout  = sel ? b3.bus_dout : b1.bus_dout;
  assign w_rdata = sel ? b3.rdata    : b1.rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [6:0] exp);
    @(posedge clk); #1;
    check(tag, {25'd0, w_status}, {25'd0, exp});
  endtask

  task automatic request(input logic [1:0] o, input logic [15:0] a, input logic [7:0] d);
    req = 1'b1; op = o; addr = a; wdata = d;
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; req = 1'b0; op = 2'b00; addr = 16'h0;
    wdata = 8'h00; bus_din = 8'h00; wait_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_status", {25'd0, w_status}, {25'd0, c_IDLE});
    check("rst_addr",   {16'd0, w_addr},   32'h0);
    check("rst_dout",   {24'd0, w_dout},   32'h0);
    check("rst_rdata",  {24'd0, w_rdata},  32'h0);

    // Memory write 0x1234 <- 0x5A, no waits
    request(2'b01, 16'h1234, 8'h5A);
    step("mw_t1", 7'b0001111); req = 1'b0;
    check("mw_addr", {16'd0, w_addr}, 32'h1234);
    check("mw_dout", {24'd0, w_dout}, 32'h5A);
    step("mw_t2", 7'b0001101);
    step("mw_t3", 7'b1001101);
    step("mw_done", c_DONE);
    check("mw_rdata", {24'd0, w_rdata}, 32'h0);
    step("mw_idle", c_IDLE);

    // Memory read 0x8000 with two wait_n=0 samples
    request(2'b00, 16'h8000, 8'h00); wait_n = 1'b0; bus_din = 8'h11;
    step("mr_t1", 7'b0001010); req = 1'b0;
    step("mr_t2", 7'b0001010);
    step("mr_tw1", 7'b0001010);
    step("mr_tw2", 7'b0001010); wait_n = 1'b1;
    step("mr_t3", 7'b1001010); bus_din = 8'hC3;
    step("mr_done", c_DONE);
    check("mr_rdata", {24'd0, w_rdata}, 32'hC3);

    // I/O write port 0x00FE <- 0x07, one automatic TW
    request(2'b11, 16'h00FE, 8'h07);
    step("iow_t1", 7'b0011111); req = 1'b0;
    check("iow_addr", {16'd0, w_addr}, 32'h00FE);
    step("iow_t2", 7'b0010101);
    step("iow_tw", 7'b0010101);
    step("iow_t3", 7'b1010101);
    check("iow_dout", {24'd0, w_dout}, 32'h07);
    step("iow_done", c_DONE);

    // Back-to-back: mem write 0x2000 then mem read 0x2001, req held
    request(2'b01, 16'h2000, 8'h3C);
    step("bb_w_t1", 7'b0001111);
    request(2'b00, 16'h2001, 8'h00);
    step("bb_w_t2", 7'b0001101);
    step("bb_w_t3", 7'b1001101);
    check("bb_addr_hold", {16'd0, w_addr}, 32'h2000);
    step("bb_r_t1_done", 7'b0101010); req = 1'b0;
    check("bb_addr2", {16'd0, w_addr}, 32'h2001);
    step("bb_r_t2", 7'b0001010);
    step("bb_r_t3", 7'b1001010); bus_din = 8'h96;
    step("bb_r_done", c_DONE);
    check("bb_rdata", {24'd0, w_rdata}, 32'h96);

    // Reset during the automatic TW of an I/O read
    request(2'b10, 16'h0042, 8'h00);
    step("rtw_t1", 7'b0011110); req = 1'b0;
    step("rtw_t2", 7'b0010010);
    step("rtw_tw", 7'b0010010); reset = 1'b1; bus_din = 8'hAA;
    step("rtw_reset", c_IDLE);
    check("rtw_rdata", {24'd0, w_rdata}, 32'h0);
    reset = 1'b0;
    step("rtw_nodone", c_IDLE);

    // IO_WAIT_STATES=3 unit: I/O read, wait_n low through the automatic waits
    sel = 1'b1; bus_din = 8'h5E; wait_n = 1'b0;
    #1 check("io3_idle", {25'd0, w_status}, {25'd0, c_IDLE});
    request(2'b10, 16'h0010, 8'h00);
    step("io3_t1", 7'b0011110); req = 1'b0;
    step("io3_t2", 7'b0010010);
    for (int i = 0; i < 4; i++) step("io3_tw", 7'b0010010);
    wait_n = 1'b1;
    step("io3_t3", 7'b1010010);
    step("io3_done", c_DONE);
    check("io3_rdata", {24'd0, w_rdata}, 32'h5E);
    step("io3_idle2", c_IDLE);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
